// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace capture block: record layout and widths.
package cpu_trace_pkg;

    // Record field offsets, LSB first: pc, cycle stamp, reg_wr, misaligned
    localparam int unsigned REC_PC_LSB  = 0;
    localparam int unsigned REC_PC_W    = 32;
    localparam int unsigned REC_CYC_LSB = 32;

    // Width of the saturating drop counter
    localparam int unsigned DROP_W = 16;

    // Total record width for a given cycle-stamp width
    function automatic int unsigned rec_width(input int unsigned cyc_w);
        return REC_PC_W + cyc_w + 2;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with occupancy reporting.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter  int unsigned WIDTH = 50,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign valid_o = !empty_o;
    assign level_o = lvl_q;
    // Head is muxed to zero while empty so the output reads 0 straight after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for pointers (wrap naturally at power-of-two depth) and level
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    // Pointer and level registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// Trace monitor for cpu_top: stamps PC/reg-write samples with a cycle count,
// buffers them in a FWFT FIFO and counts records lost to overflow.
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned CYC_W = 16,
    localparam int unsigned REC_W = rec_width(CYC_W),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_in,
    input  logic              reg_wr_in,
    input  logic              trace_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REC_W-1:0]  out_data,
    output logic [LVL_W-1:0]  level,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              misalign_seen
);

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              seen_q, seen_d;
    logic [REC_W-1:0]  rec;
    logic              misaligned;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              rejected;

    assign misaligned = |pc_in[1:0];
    assign pop        = !fifo_empty && out_ready;
    assign push_ok    = trace_en && (!fifo_full || pop);
    assign rejected   = trace_en && fifo_full && !pop;

    // Pack the record: {misaligned, reg_wr, cycle, pc}
    always_comb begin
        rec                              = '0;
        rec[REC_PC_LSB +: REC_PC_W]      = pc_in;
        rec[REC_CYC_LSB +: CYC_W]        = cyc_q;
        rec[REC_CYC_LSB + CYC_W]         = reg_wr_in;
        rec[REC_CYC_LSB + CYC_W + 1]     = misaligned;
    end

    // Next-state for cycle counter, saturating drop count and sticky flag
    always_comb begin
        cyc_d  = cyc_q + CYC_W'(1);
        drop_d = drop_q;
        seen_d = seen_q;
        if (rejected && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
        if (trace_en && misaligned)     seen_d = 1'b1;
    end

    // Monitor state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q  <= '0;
            drop_q <= '0;
            seen_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            drop_q <= drop_d;
            seen_q <= seen_d;
        end
    end

    assign drop_cnt      = drop_q;
    assign misalign_seen = seen_q;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .data_i  (rec),
        .pop_i   (pop),
        .data_o  (out_data),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench for cpu_trace_capture: directed plan plus random traffic,
// checked against a queue-based reference model. A second instance with a
// 4-bit cycle stamp shares the stimulus to exercise stamp wrap-around.
module tb_cpu_trace_capture;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] pc_in;
    logic        reg_wr_in;
    logic        trace_en;
    logic        out_ready;

    logic        ov_a, ms_a;
    logic [49:0] od_a;
    logic [4:0]  lv_a;
    logic [15:0] dc_a;

    logic        ov_b, ms_b;
    logic [37:0] od_b;
    logic [4:0]  lv_b;
    logic [15:0] dc_b;

    cpu_trace_capture #(.DEPTH(16), .CYC_W(16)) u_dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .reg_wr_in(reg_wr_in),
        .trace_en(trace_en), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .level(lv_a), .drop_cnt(dc_a), .misalign_seen(ms_a)
    );

    cpu_trace_capture #(.DEPTH(16), .CYC_W(4)) u_dut_w4 (
        .clk(clk), .reset(reset), .pc_in(pc_in), .reg_wr_in(reg_wr_in),
        .trace_en(trace_en), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .level(lv_b), .drop_cnt(dc_b), .misalign_seen(ms_b)
    );

    // Reference model: a queue of captured samples with absolute cycle numbers
    typedef struct {
        logic [31:0] pc;
        logic        rw;
        int unsigned cyc;
    } rec_t;

    rec_t        mq[$];
    int unsigned mcyc  = 0;
    int unsigned mdrop = 0;
    bit          mseen = 0;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    function automatic logic [63:0] rec_bits(input rec_t r, input int unsigned cw);
        logic [63:0] v;
        logic [31:0] c;
        logic [31:0] m;
        c = r.cyc;
        m = (32'd1 << cw) - 32'd1;
        v = 64'(r.pc);
        v = v | (64'(c & m) << 32);
        v[32 + cw] = r.rw;
        v[33 + cw] = (r.pc[1:0] != 2'b00);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit after_reset);
        check("valid",    64'(ov_a), 64'(mq.size() != 0));
        check("level",    64'(lv_a), 64'(mq.size()));
        check("drop",     64'(dc_a), 64'(mdrop));
        check("seen",     64'(ms_a), 64'(mseen));
        check("w4_valid", 64'(ov_b), 64'(mq.size() != 0));
        check("w4_level", 64'(lv_b), 64'(mq.size()));
        check("w4_drop",  64'(dc_b), 64'(mdrop));
        check("w4_seen",  64'(ms_b), 64'(mseen));
        if (mq.size() != 0) begin
            check("data",    64'(od_a), rec_bits(mq[0], 16));
            check("w4_data", 64'(od_b), rec_bits(mq[0], 4));
        end
        if (after_reset) begin
            check("rst_data",    64'(od_a), 64'd0);
            check("w4_rst_data", 64'(od_b), 64'd0);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare
    task automatic tick(input logic rst_n, input logic en, input logic [31:0] pc,
                        input logic rw, input logic rdy);
        bit   pop;
        bit   room;
        rec_t r;
        reset     = rst_n;
        trace_en  = en;
        pc_in     = pc;
        reg_wr_in = rw;
        out_ready = rdy;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            mcyc  = 0;
            mdrop = 0;
            mseen = 0;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            room = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (en) begin
                if (room) begin
                    r.pc  = pc;
                    r.rw  = rw;
                    r.cyc = mcyc;
                    mq.push_back(r);
                end else if (mdrop < 65535) begin
                    mdrop++;
                end
                if (pc[1:0] != 2'b00) mseen = 1;
            end
            mcyc++;
        end
        check_all(!rst_n);
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b0; trace_en = 1'b0; pc_in = '0; reg_wr_in = 1'b0; out_ready = 1'b0;

        // Reset state
        tick(0, 0, 32'h0, 0, 0);
        tick(0, 0, 32'h0, 0, 0);

        // Three captures, then drain: stamps 0,1,2, aligned
        tick(1, 1, 32'h0, 0, 0);
        tick(1, 1, 32'h4, 1, 0);
        tick(1, 1, 32'h8, 0, 0);
        check("plan_level3", 64'(lv_a), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("plan_stamp", 64'(od_a[47:32]), 64'(i));
            check("plan_misal", 64'(od_a[49]), 64'd0);
            tick(1, 0, 32'h0, 0, 1);
        end

        // Overflow: 20 captures into 16 entries
        tick(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 20; i++)
            tick(1, 1, 32'h100 + 32'(4 * i), 1'(i & 1), 0);
        check("ovf_level", 64'(lv_a), 64'd16);
        check("ovf_drop",  64'(dc_a), 64'd4);
        check("ovf_head",  64'(od_a[31:0]), 64'h100);

        // Full with simultaneous push and pop for 10 cycles
        for (int i = 0; i < 10; i++)
            tick(1, 1, 32'h200 + 32'(4 * i), 0, 1);
        check("fullpp_level", 64'(lv_a), 64'd16);
        check("fullpp_drop",  64'(dc_a), 64'd4);

        // Misalignment sticky flag
        tick(0, 0, 32'h0, 0, 0);
        tick(1, 0, 32'h3, 0, 0);
        check("misal_uncaptured", 64'(ms_a), 64'd0);
        tick(1, 1, 32'h4, 0, 0);
        check("misal_before", 64'(ms_a), 64'd0);
        tick(1, 1, 32'h6, 0, 0);
        check("misal_set", 64'(ms_a), 64'd1);
        for (int i = 0; i < 3; i++) tick(1, 1, 32'h10 + 32'(4 * i), 0, 0);
        for (int i = 0; i < 6; i++) tick(1, 0, 32'h0, 0, 1);
        check("misal_hold", 64'(ms_a), 64'd1);

        // Cycle-stamp wrap on the 4-bit instance
        tick(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 15; i++) tick(1, 0, 32'h0, 0, 0);
        tick(1, 1, 32'h40, 0, 0);
        tick(1, 1, 32'h44, 1, 0);
        check("wrap_stamp15", 64'(od_b[35:32]), 64'd15);
        tick(1, 0, 32'h0, 0, 1);
        check("wrap_stamp0",  64'(od_b[35:32]), 64'd0);
        check("wrap_stamp16", 64'(od_a[47:32]), 64'd16);
        tick(1, 0, 32'h0, 0, 1);

        // Reset mid-operation with level 5 and drop 7
        tick(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 23; i++) tick(1, 1, 32'h300 + 32'(4 * i), 0, 0);
        for (int i = 0; i < 11; i++) tick(1, 0, 32'h0, 0, 1);
        check("mid_level5", 64'(lv_a), 64'd5);
        check("mid_drop7",  64'(dc_a), 64'd7);
        tick(0, 1, 32'h500, 1, 1);
        check("mid_rst_valid", 64'(ov_a), 64'd0);
        check("mid_rst_level", 64'(lv_a), 64'd0);
        check("mid_rst_drop",  64'(dc_a), 64'd0);

        // Random traffic with alternating sink back-pressure
        for (int i = 0; i < 800; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            tick(($urandom_range(0, 249) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 rpc,
                 1'($urandom_range(0, 1)),
                 ((i / 100) % 2 == 0) ? (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0)
                                      : (($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
